// File: rtl/dm_responder.sv
// Multi-cycle data-memory responder: valid/ready request port, busy stall
// output and a one-cycle completion pulse per access.
module dm_responder #(
  parameter int    AW        = 7,
  parameter int    LAT       = 2,
  parameter string INIT_FILE = ""
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_wr,
  input  logic [AW-1:0] req_addr,
  input  logic [31:0]   req_wdata,
  input  logic [3:0]    req_be,
  output logic          busy,
  output logic          resp_valid,
  output logic [31:0]   resp_rdata,
  output logic [15:0]   acc_count
);

  // Latencies below 1 behave as 1; the counter only has to hold LAT-1.
  localparam int             LAT_E    = (LAT < 1) ? 1 : LAT;
  localparam int             CW       = (LAT_E > 1) ? $clog2(LAT_E) : 1;
  localparam logic [CW-1:0]  CNT_LOAD = CW'(LAT_E - 1);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] cnt;

  logic          wr_q;
  logic [AW-1:0] addr_q;
  logic [31:0]   wdata_q;
  logic [3:0]    be_q;

  logic [31:0]   mem [0:(2**AW)-1];

  logic          accept;
  logic          done;

  assign req_ready  = (state == IDLE) || (state == RESP);
  assign busy       = (state == BUSY);
  assign resp_valid = (state == RESP);
  assign accept     = req_valid && req_ready;
  assign done       = (state == BUSY) && (cnt == '0);

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (accept) state_nxt = BUSY;
      BUSY:    if (cnt == '0) state_nxt = RESP;
      RESP:    state_nxt = accept ? BUSY : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      resp_rdata <= '0;
      acc_count  <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        cnt <= CNT_LOAD;
      end else if ((state == BUSY) && (cnt != '0)) begin
        cnt <= cnt - CW'(1);
      end
      if (done) begin
        acc_count <= acc_count + 16'd1;
        if (!wr_q) begin
          resp_rdata <= mem[addr_q];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      wr_q    <= req_wr;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
      be_q    <= req_be;
    end
  end

  // The write is gated by the registered state, so an access cut short by
  // reset never reaches the array; the array itself is never cleared.
  always_ff @(posedge clk) begin
    if (done && wr_q) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (be_q[i]) begin
          mem[addr_q][8*i +: 8] <= wdata_q[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_dm_responder.sv
// Self-checking bench for dm_responder: scoreboarded LAT=2 instance plus
// LAT=4 (reset mid-access) and LAT=0/LAT=1 (minimum latency) instances.
module tb_dm_responder;

  localparam int AW = 7;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic rst_n;
  logic rst4;

  // LAT=2 instance
  logic          v, ready, wr, busy, rv;
  logic [AW-1:0] addr;
  logic [31:0]   wdata, rdata;
  logic [3:0]    be;
  logic [15:0]   acc;

  // LAT=4 instance
  logic          v4, ready4, wr4, busy4, rv4;
  logic [AW-1:0] addr4;
  logic [31:0]   wdata4, rdata4;
  logic [3:0]    be4;
  logic [15:0]   acc4;

  // LAT=0 and LAT=1 instances share stimulus
  logic          v01, wr01;
  logic [AW-1:0] addr01;
  logic [31:0]   wdata01;
  logic [3:0]    be01;
  logic          ready0, busy0, rv0, ready1, busy1, rv1;
  logic [31:0]   rdata0, rdata1;
  logic [15:0]   acc0, acc1;

  dm_responder #(.AW(AW), .LAT(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .req_valid(v), .req_ready(ready), .req_wr(wr),
    .req_addr(addr), .req_wdata(wdata), .req_be(be), .busy(busy),
    .resp_valid(rv), .resp_rdata(rdata), .acc_count(acc)
  );

  dm_responder #(.AW(AW), .LAT(4)) dut4 (
    .clk(clk), .rst_n(rst4), .req_valid(v4), .req_ready(ready4), .req_wr(wr4),
    .req_addr(addr4), .req_wdata(wdata4), .req_be(be4), .busy(busy4),
    .resp_valid(rv4), .resp_rdata(rdata4), .acc_count(acc4)
  );

  dm_responder #(.AW(AW), .LAT(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .req_valid(v01), .req_ready(ready0), .req_wr(wr01),
    .req_addr(addr01), .req_wdata(wdata01), .req_be(be01), .busy(busy0),
    .resp_valid(rv0), .resp_rdata(rdata0), .acc_count(acc0)
  );

  dm_responder #(.AW(AW), .LAT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .req_valid(v01), .req_ready(ready1), .req_wr(wr01),
    .req_addr(addr01), .req_wdata(wdata01), .req_be(be01), .busy(busy1),
    .resp_valid(rv1), .resp_rdata(rdata1), .acc_count(acc1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Scoreboard for the LAT=2 instance
  typedef struct {
    int unsigned cyc;
    logic [31:0] rdata;
  } exp_t;

  exp_t        sbq[$];
  exp_t        mon_e;
  logic [31:0] mdl [0:(2**AW)-1];
  logic [31:0] last_load = '0;
  logic [15:0] exp_acc = '0;
  int unsigned last_resp_cyc = 0;
  int unsigned prev_resp_cyc = 0;
  logic        prev_rv = 1'b0;

  always @(negedge clk) begin
    if (rst_n && rv) begin
      check("pulse_len", {31'd0, prev_rv}, 32'd0);
      if (sbq.size() == 0) begin
        check("spurious_resp", {31'd0, rv}, 32'd0);
      end else begin
        mon_e = sbq.pop_front();
        exp_acc = exp_acc + 16'd1;
        check("latency", cyc - mon_e.cyc, 32'd2);
        check("rdata", rdata, mon_e.rdata);
        check("acc_count", {16'd0, acc}, {16'd0, exp_acc});
      end
      prev_resp_cyc = last_resp_cyc;
      last_resp_cyc = cyc;
    end
    prev_rv = rv;
  end

  // Presents a request and returns #1 after the accepting edge with req_valid
  // still high, so a following call forms a back-to-back pair.
  task automatic issue(input logic w, input logic [AW-1:0] a, input logic [31:0] d,
                       input logic [3:0] b);
    logic        r;
    int unsigned n;
    exp_t        e;
    wr = w; addr = a; wdata = d; be = b; v = 1'b1;
    n = 0;
    r = 1'b0;
    while (n < 50) begin
      r = ready;
      @(posedge clk);
      n++;
      if (r) break;
      #1;
    end
    #1;
    check("accepted", {31'd0, r}, 32'd1);
    if (!r) return;
    e.cyc = cyc;
    if (w) begin
      for (int i = 0; i < 4; i++) begin
        if (b[i]) mdl[a][8*i +: 8] = d[8*i +: 8];
      end
      e.rdata = last_load;
    end else begin
      e.rdata = mdl[a];
      last_load = e.rdata;
    end
    sbq.push_back(e);
  endtask

  task automatic drain();
    int unsigned n;
    n = 0;
    while (sbq.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("drain", sbq.size(), 32'd0);
  endtask

  task automatic idle();
    v = 1'b0; wr = 'x; addr = 'x; wdata = 'x; be = 'x;
  endtask

  // Waits (bounded) for resp_valid on the LAT=4 instance
  task automatic wait_rv4(input string tag);
    int unsigned n;
    n = 0;
    while (!rv4 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check(tag, {31'd0, rv4}, 32'd1);
  endtask

  // Waits (bounded) for LAT=4 acceptance, then drops req_valid
  task automatic accept4(input string tag);
    logic        r;
    int unsigned n;
    n = 0;
    r = 1'b0;
    while (n < 20) begin
      r = ready4;
      @(posedge clk);
      n++;
      if (r) break;
      #1;
    end
    #1;
    v4 = 1'b0;
    check(tag, {31'd0, r}, 32'd1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; rst4 = 1'b0;
    idle();
    v4 = 1'b0; wr4 = 1'b0; addr4 = '0; wdata4 = '0; be4 = '0;
    v01 = 1'b0; wr01 = 1'b0; addr01 = '0; wdata01 = '0; be01 = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_rv", {31'd0, rv}, 32'd0);
    check("rst_acc", {16'd0, acc}, 32'd0);
    check("rst_rdata", rdata, 32'd0);
    rst_n = 1'b1; rst4 = 1'b1;
    #1;
    check("rst_ready", {31'd0, ready}, 32'd1);

    // Store then load at LAT=2
    issue(1'b1, 7'd5, 32'hDEADBEEF, 4'hF);
    check("busy_after_accept", {31'd0, busy}, 32'd1);
    idle();
    drain();
    check("acc_after_store", {16'd0, acc}, 32'd1);
    issue(1'b0, 7'd5, '0, 4'h0);
    idle();
    drain();
    check("load_data", rdata, 32'hDEADBEEF);
    check("acc_after_load", {16'd0, acc}, 32'd2);

    // Byte enables
    issue(1'b1, 7'd3, 32'h11223344, 4'hF);
    idle();
    drain();
    issue(1'b1, 7'd3, 32'hAABBCCDD, 4'b0101);
    idle();
    drain();
    issue(1'b0, 7'd3, '0, 4'h0);
    idle();
    drain();
    check("be_merge", rdata, 32'h11BB33DD);
    issue(1'b1, 7'd3, 32'hFFFFFFFF, 4'h0);
    idle();
    drain();
    issue(1'b0, 7'd3, '0, 4'h0);
    idle();
    drain();
    check("be_zero", rdata, 32'h11BB33DD);

    // Back-to-back store then load, req_valid held high throughout
    issue(1'b1, 7'd9, 32'h12345678, 4'hF);
    issue(1'b0, 7'd9, '0, 4'h0);
    idle();
    drain();
    check("b2b_gap", last_resp_cyc - prev_resp_cyc, 32'd3);
    check("b2b_data", rdata, 32'h12345678);

    // Counter wrap
    repeat (3) @(posedge clk);
    @(negedge clk);
    force dut2.acc_count = 16'hFFFF;
    @(posedge clk);
    #1;
    release dut2.acc_count;
    exp_acc = 16'hFFFF;
    check("acc_preload", {16'd0, acc}, 32'h0000FFFF);
    issue(1'b1, 7'd11, 32'h0BADF00D, 4'hF);
    idle();
    drain();
    check("acc_wrap", {16'd0, acc}, 32'd0);

    // Reset mid-access at LAT=4
    wr4 = 1'b1; addr4 = 7'd2; wdata4 = 32'h0; be4 = 4'hF; v4 = 1'b1;
    accept4("r4_accept_init");
    wait_rv4("r4_init_resp");
    check("r4_acc_before", {16'd0, acc4}, 32'd1);
    @(posedge clk);
    #1;
    wr4 = 1'b1; addr4 = 7'd2; wdata4 = 32'hCAFEF00D; be4 = 4'hF; v4 = 1'b1;
    accept4("r4_accept_store");
    @(posedge clk);
    #1;
    rst4 = 1'b0;
    #1;
    check("r4_busy", {31'd0, busy4}, 32'd0);
    check("r4_rv", {31'd0, rv4}, 32'd0);
    check("r4_ready", {31'd0, ready4}, 32'd1);
    check("r4_acc", {16'd0, acc4}, 32'd0);
    @(posedge clk);
    #1;
    rst4 = 1'b1;
    wr4 = 1'b0; addr4 = 7'd2; v4 = 1'b1;
    accept4("r4_accept_load");
    wait_rv4("r4_load_resp");
    check("r4_load_data", rdata4, 32'h0);
    check("r4_acc_after", {16'd0, acc4}, 32'd1);

    // LAT=0 and LAT=1: one-edge latency, identical timing
    @(posedge clk);
    #1;
    check("l01_ready0", {31'd0, ready0}, 32'd1);
    check("l01_ready1", {31'd0, ready1}, 32'd1);
    wr01 = 1'b1; addr01 = 7'd7; wdata01 = 32'h5A5A1234; be01 = 4'hF; v01 = 1'b1;
    @(posedge clk);
    #1;
    v01 = 1'b0;
    check("l0_busy", {31'd0, busy0}, 32'd1);
    check("l1_busy", {31'd0, busy1}, 32'd1);
    check("l0_rv_early", {31'd0, rv0}, 32'd0);
    @(posedge clk);
    #1;
    check("l0_store_rv", {31'd0, rv0}, 32'd1);
    check("l1_store_rv", {31'd0, rv1}, 32'd1);
    wr01 = 1'b0; addr01 = 7'd7; v01 = 1'b1;
    @(posedge clk);
    #1;
    v01 = 1'b0;
    check("l0_load_busy", {31'd0, busy0}, 32'd1);
    check("l1_load_rv_early", {31'd0, rv1}, 32'd0);
    @(posedge clk);
    #1;
    check("l0_load_rv", {31'd0, rv0}, 32'd1);
    check("l1_load_rv", {31'd0, rv1}, 32'd1);
    check("l0_load_data", rdata0, 32'h5A5A1234);
    check("l1_load_data", rdata1, 32'h5A5A1234);
    check("l0_acc", {16'd0, acc0}, 32'd2);
    check("l1_acc", {16'd0, acc1}, 32'd2);
    @(posedge clk);
    #1;
    check("l0_rv_drop", {31'd0, rv0}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
